dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory side of the load/store interface. Consumes retired stores (`store_wb` plus store fields) and memory-bound loads (`load_mem` plus load fields) issued by the LSQ.
- Owns a byte-addressed, little-endian data RAM. Stores are buffered in a small committed-store queue and drained one per cycle.
- Loads are checked against that queue and returned with a registered response tagged with `pd` and `rob_tag` for PRF/ROB writeback.

Parameters:
- MEM_BYTES, 1024, data RAM size in bytes (power of 2); index = `addr[$clog2(MEM_BYTES)-1:0]`, upper bits ignored.
- SQ_DEPTH, 4, committed-store queue entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- store_wb  in  1  retired store valid, one per cycle max, never back-pressured.
- store_addr  in  32  store byte address.
- store_data  in  32  store data (ps2_data).
- store_sh  in  1  0 = sw (4 bytes), 1 = sh (low 2 bytes).
- load_valid  in  1  load request (LSQ load_mem).
- load_ready  out  1  load accepted when load_valid && load_ready.
- load_addr  in  32  load byte address.
- load_func3  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- load_pd  in  7  destination physical register.
- load_rob_tag  in  5  ROB tag of the load.
- flush  in  1  mispredict recovery; kills the held load.
- load_done  out  1  one-cycle response pulse.
- load_data  out  32  extended load result.
- load_pd_out  out  7  pd of the completed load.
- load_rob_out  out  5  rob_tag of the completed load.
- sq_count  out  $clog2(SQ_DEPTH)+1  occupied store-queue entries (debug/perf).

Behaviour:
- Reset (synchronous): state = IDLE, queue empty, `sq_count` = 0, `load_done` = 0, `load_data` = 0, `load_pd_out` = 0, `load_rob_out` = 0. RAM contents are not reset; the testbench preloads them.
- Store queue: circular FIFO with wr_ptr, rd_ptr and count.
  - `store_wb` enqueues {addr, data, sh} at wr_ptr; pointers wrap modulo SQ_DEPTH.
  - Drain: head entry is written to RAM; sw writes bytes addr..addr+3 with data[7:0] at addr; sh writes addr..addr+1. Byte indices wrap modulo MEM_BYTES.
  - Single RAM port: each cycle performs either one drain write or one load read.
  - Forced drain: when count == SQ_DEPTH, the drain takes the port that cycle. An enqueue in the same cycle is legal, so the queue never overflows.
  - Otherwise the drain occurs whenever the port is not used by a load read.
  - `sq_count` is registered and equals count.
- Load FSM, states IDLE and HOLD:
  - `load_ready` = (state == IDLE) && !flush.
  - IDLE: on accept, latch addr/func3/pd/rob_tag and go to HOLD.
  - HOLD, blocked: stay in HOLD if any valid queue entry's byte range overlaps the load's byte range (1/2/4 bytes by func3), or a forced drain is active.
  - HOLD, unblocked: read RAM combinationally, register the result into the `load_*` outputs, pulse `load_done` the next cycle, and return to IDLE.
  - A blocked load waits until the overlapping entries have drained, which guarantees that committed older stores are visible to it.
  - Minimum latency: accept at edge N, `load_done` high in the cycle after edge N+1. Throughput: one load per 2 cycles.
- Overlap check: uses registered queue entries only. A store enqueued in the same cycle is checked from the next cycle.
- Extension:
  - lb sign-extends byte 0; lbu zero-extends it.
  - lh sign-extends bytes 0–1; lhu zero-extends them.
  - lw returns bytes 0–3.
  - Any other func3 is treated as lw.
- Misaligned addresses are allowed; bytes are gathered individually with wrap.
- flush:
  - Clears HOLD to IDLE with no `load_done`.
  - `load_ready` is 0 during the flush cycle.
  - A response already registered (`load_done` high in the flush cycle) still completes; the ROB discards it by tag.
  - The store queue is never flushed, because its entries are committed.
- Simultaneous store_wb + forced drain + HOLD: drain wins the port, enqueue proceeds, and the load retries next cycle.
- `load_done` is otherwise 0; the data/pd/rob outputs hold their last values.

Test Plan:
- Preload RAM[0x10..0x13] = 11 22 33 44; lw 0x10, pd = 5, rob = 3 → `load_done` 2 cycles after accept with `load_data` = 0x44332211, `load_pd_out` = 5, `load_rob_out` = 3.
- lb 0x13 with byte 0x84 → 0xFFFFFF84; lbu → 0x00000084; lhu 0x12 over bytes 33 44 → 0x00004433.
- sw 0x20 = 0xDEADBEEF, then immediately lw 0x20 → load stays in HOLD until the store drains, then returns 0xDEADBEEF; sh 0x22 = 0x1234 then lw 0x20 → 0x1234BEEF.
- Issue 5 back-to-back stores with a load continuously in HOLD to an unrelated address → `sq_count` never exceeds 4, the forced drain occurs, all 5 stores land, and the load completes.
- Accept lw, assert flush the next cycle → no `load_done`; `load_ready` returns to 1 the following cycle.
- Assert reset mid-HOLD with 3 stores queued → `sq_count` = 0, IDLE, `load_done` = 0, and the queued stores are not written.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory controller: committed-store queue draining into a byte-addressed
// little-endian RAM, plus a single-entry load path that waits out overlapping stores.
module dmem_ctrl #(
   parameter int MEM_BYTES = 1024,
   parameter int SQ_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          store_wb,
   input  logic [31:0]                   store_addr,
   input  logic [31:0]                   store_data,
   input  logic                          store_sh,
   input  logic                          load_valid,
   output logic                          load_ready,
   input  logic [31:0]                   load_addr,
   input  logic [2:0]                    load_func3,
   input  logic [6:0]                    load_pd,
   input  logic [4:0]                    load_rob_tag,
   input  logic                          flush,
   output logic                          load_done,
   output logic [31:0]                   load_data,
   output logic [6:0]                    load_pd_out,
   output logic [4:0]                    load_rob_out,
   output logic [$clog2(SQ_DEPTH):0]     sq_count
);

   localparam int IW = $clog2(MEM_BYTES);
   localparam int PW = $clog2(SQ_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t          state_r;
   logic [IW-1:0]   sq_addr_r [SQ_DEPTH];
   logic [31:0]     sq_data_r [SQ_DEPTH];
   logic            sq_sh_r   [SQ_DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic [IW-1:0]   ld_addr_r;
   logic [2:0]      ld_func3_r;
   logic [6:0]      ld_pd_r;
   logic [4:0]      ld_rob_r;
   logic [7:0]      mem [MEM_BYTES];

   logic            full_s;
   logic            overlap_s;
   logic            blocked_s;
   logic            load_rd_s;
   logic            drain_s;
   logic [31:0]     rd_word_s;
   logic [IW-1:0]   head_addr_s;
   logic [31:0]     head_data_s;
   logic            head_sh_s;
   logic            unused_s;

   function automatic logic [2:0] acc_size(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: acc_size = 3'd1;
         3'b001, 3'b101: acc_size = 3'd2;
         default:        acc_size = 3'd4;
      endcase
   endfunction

   // True when any byte of [la, la+lsz) hits any byte of [sa, sa+ssz), modulo RAM size.
   function automatic logic bytes_overlap(input logic [IW-1:0] la, input logic [2:0] lsz,
                                          input logic [IW-1:0] sa, input logic [2:0] ssz);
      logic          hit;
      logic [IW-1:0] lb;
      logic [IW-1:0] sb;
      hit = 1'b0;
      for (int j = 0; j < 4; j++) begin
         for (int k = 0; k < 4; k++) begin
            lb  = la + IW'(j);
            sb  = sa + IW'(k);
            hit = hit | ((3'(j) < lsz) && (3'(k) < ssz) && (lb == sb));
         end
      end
      return hit;
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  extend = {{24{w[7]}}, w[7:0]};
         3'b100:  extend = {24'h000000, w[7:0]};
         3'b001:  extend = {{16{w[15]}}, w[15:0]};
         3'b101:  extend = {16'h0000, w[15:0]};
         default: extend = w;
      endcase
   endfunction

   assign unused_s    = ^{store_addr[31:IW], load_addr[31:IW]};
   assign full_s      = (count_r == CW'(SQ_DEPTH));
   assign head_addr_s = sq_addr_r[rd_ptr_r];
   assign head_data_s = sq_data_r[rd_ptr_r];
   assign head_sh_s   = sq_sh_r[rd_ptr_r];
   assign load_ready  = (state_r == IDLE) && !flush;
   assign sq_count    = count_r;

   // Scan the occupied queue slots for any byte shared with the held load.
   always_comb begin
      logic [PW-1:0] off;
      overlap_s = 1'b0;
      off       = '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
         off       = PW'(i) - rd_ptr_r;
         overlap_s = overlap_s | (({1'b0, off} < count_r) &&
                     bytes_overlap(ld_addr_r, acc_size(ld_func3_r),
                                   sq_addr_r[i], sq_sh_r[i] ? 3'd2 : 3'd4));
      end
   end

   // Port arbitration: a full queue always wins; otherwise loads read first.
   always_comb begin
      blocked_s = overlap_s || full_s;
      load_rd_s = (state_r == HOLD) && !blocked_s && !flush;
      drain_s   = (count_r != CW'(0)) && (full_s || !load_rd_s);
   end

   // Gather the four load bytes individually so misaligned accesses wrap.
   always_comb begin
      rd_word_s = 32'h0000_0000;
      for (int j = 0; j < 4; j++) begin
         rd_word_s[8*j +: 8] = mem[ld_addr_r + IW'(j)];
      end
   end

   // RAM write port driven by the queue head; contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && drain_s) begin
         for (int k = 0; k < 4; k++) begin
            if ((k < 2) || !head_sh_s) begin
               mem[head_addr_s + IW'(k)] <= head_data_s[8*k +: 8];
            end
         end
      end
   end

   // Queue payload storage; only pointers and count need resetting.
   always_ff @(posedge clk) begin
      if (store_wb) begin
         sq_addr_r[wr_ptr_r] <= store_addr[IW-1:0];
         sq_data_r[wr_ptr_r] <= store_data;
         sq_sh_r[wr_ptr_r]   <= store_sh;
      end
   end

   // Queue pointers, load FSM and registered response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         count_r      <= '0;
         ld_addr_r    <= '0;
         ld_func3_r   <= 3'b000;
         ld_pd_r      <= 7'd0;
         ld_rob_r     <= 5'd0;
         load_done    <= 1'b0;
         load_data    <= 32'h0000_0000;
         load_pd_out  <= 7'd0;
         load_rob_out <= 5'd0;
      end else begin
         if (store_wb) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (drain_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
         count_r <= count_r + CW'(store_wb) - CW'(drain_s);

         case (state_r)
            IDLE: begin
               if (load_valid && load_ready) begin
                  ld_addr_r  <= load_addr[IW-1:0];
                  ld_func3_r <= load_func3;
                  ld_pd_r    <= load_pd;
                  ld_rob_r   <= load_rob_tag;
                  state_r    <= HOLD;
               end
            end
            HOLD: begin
               if (flush || !blocked_s) state_r <= IDLE;
            end
            default: state_r <= IDLE;
         endcase

         load_done <= load_rd_s;
         if (load_rd_s) begin
            load_data    <= extend(ld_func3_r, rd_word_s);
            load_pd_out  <= ld_pd_r;
            load_rob_out <= ld_rob_r;
         end
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: load extension, store forwarding by stalling,
// forced drain, flush and reset behaviour, with hand-computed expectations.
module tb_dmem_ctrl;

   logic        clk;
   logic        reset;
   logic        store_wb;
   logic [31:0] store_addr;
   logic [31:0] store_data;
   logic        store_sh;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_addr;
   logic [2:0]  load_func3;
   logic [6:0]  load_pd;
   logic [4:0]  load_rob_tag;
   logic        flush;
   logic        load_done;
   logic [31:0] load_data;
   logic [6:0]  load_pd_out;
   logic [4:0]  load_rob_out;
   logic [2:0]  sq_count;

   int checks = 0;
   int errors = 0;

   dmem_ctrl #(.MEM_BYTES(1024), .SQ_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .store_wb(store_wb), .store_addr(store_addr), .store_data(store_data), .store_sh(store_sh),
      .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
      .load_func3(load_func3), .load_pd(load_pd), .load_rob_tag(load_rob_tag),
      .flush(flush), .load_done(load_done), .load_data(load_data),
      .load_pd_out(load_pd_out), .load_rob_out(load_rob_out), .sq_count(sq_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic sh);
      store_wb = 1'b1; store_addr = a; store_data = d; store_sh = sh;
      tick;
      store_wb = 1'b0;
   endtask

   task automatic wait_drain;
      for (int n = 0; n < 20; n++) begin
         if (sq_count == 3'd0) break;
         tick;
      end
      chk("drain_empty", 32'(sq_count), 32'd0);
   endtask

   // Issue one load (optionally with a same-cycle store) and wait for its response.
   task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [6:0] pd,
                          input logic [4:0] rob, input logic st_en, input logic [31:0] st_a,
                          input logic [31:0] st_d, input logic st_sh,
                          output logic [31:0] d, output int lat);
      load_valid = 1'b1; load_addr = a; load_func3 = f3; load_pd = pd; load_rob_tag = rob;
      store_wb = st_en; store_addr = st_a; store_data = st_d; store_sh = st_sh;
      tick;
      load_valid = 1'b0;
      store_wb = 1'b0;
      lat = 0;
      for (int n = 0; n < 20; n++) begin
         tick;
         lat++;
         if (load_done) break;
      end
      chk("load_done_seen", 32'(load_done), 32'd1);
      d = load_data;
   endtask

   logic [31:0] rd;
   int          lat;
   int          maxc;
   int          pulses;
   int          accepts;

   initial begin
      reset = 1'b1; store_wb = 1'b0; store_addr = '0; store_data = '0; store_sh = 1'b0;
      load_valid = 1'b0; load_addr = '0; load_func3 = 3'b010; load_pd = '0; load_rob_tag = '0;
      flush = 1'b0;
      tick; tick;
      chk("rst_sq_count", 32'(sq_count), 32'd0);
      chk("rst_load_done", 32'(load_done), 32'd0);
      chk("rst_load_data", load_data, 32'h0);
      chk("rst_pd", 32'(load_pd_out), 32'd0);
      chk("rst_rob", 32'(load_rob_out), 32'd0);
      reset = 1'b0;
      #1;
      chk("rst_ready", 32'(load_ready), 32'd1);

      // Basic lw and latency
      do_store(32'h10, 32'h44332211, 1'b0);
      wait_drain;
      do_load(32'h10, 3'b010, 7'd5, 5'd3, 1'b0, '0, '0, 1'b0, rd, lat);
      chk("lw_latency", 32'(lat), 32'd1);
      chk("lw_data", rd, 32'h44332211);
      chk("lw_pd", 32'(load_pd_out), 32'd5);
      chk("lw_rob", 32'(load_rob_out), 32'd3);
      tick;
      chk("done_pulse_low", 32'(load_done), 32'd0);
      chk("data_hold", load_data, 32'h44332211);
      do_load(32'h12, 3'b101, 7'd6, 5'd4, 1'b0, '0, '0, 1'b0, rd, lat);
      chk("lhu_4433", rd, 32'h00004433);

      // Sign/zero extension on a negative byte
      do_store(32'h10, 32'h84332211, 1'b0);
      wait_drain;
      do_load(32'h13, 3'b000, 7'd7, 5'd5, 1'b0, '0, '0, 1'b0, rd, lat);
      chk("lb_neg", rd, 32'hFFFFFF84);
      do_load(32'h13, 3'b100, 7'd7, 5'd5, 1'b0, '0, '0, 1'b0, rd, lat);
      chk("lbu", rd, 32'h00000084);
      do_load(32'h12, 3'b001, 7'd7, 5'd5, 1'b0, '0, '0, 1'b0, rd, lat);
      chk("lh_neg", rd, 32'hFFFF8433);

      // Load held behind an overlapping same-cycle store
      do_load(32'h20, 3'b010, 7'd8, 5'd6, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0, rd, lat);
      chk("raw_latency", 32'(lat), 32'd2);
      chk("raw_sw", rd, 32'hDEADBEEF);
      do_load(32'h20, 3'b010, 7'd9, 5'd7, 1'b1, 32'h22, 32'h00001234, 1'b1, rd, lat);
      chk("raw_sh_latency", 32'(lat), 32'd2);
      chk("raw_sh", rd, 32'h1234BEEF);

      // Misaligned access wrapping past the top of RAM
      do_store(32'h3FE, 32'h04030201, 1'b0);
      wait_drain;
      do_load(32'h3FE, 3'b010, 7'd1, 5'd1, 1'b0, '0, '0, 1'b0, rd, lat);
      chk("wrap_lw", rd, 32'h04030201);
      do_load(32'h400, 3'b101, 7'd1, 5'd1, 1'b0, '0, '0, 1'b0, rd, lat);
      chk("wrap_upper_ignored", rd, 32'h00000403);

      // Store stream against back-to-back loads fills the queue and forces drains
      do_store(32'h100, 32'hCAFEF00D, 1'b0);
      wait_drain;
      maxc = 0; pulses = 0; accepts = 0;
      for (int i = 0; i < 12; i++) begin
         store_wb = (i < 8); store_addr = 32'h40 + 32'(4 * i);
         store_data = 32'h5A000000 + 32'(i) * 32'h01010101; store_sh = 1'b0;
         load_valid = (i < 8); load_addr = 32'h100; load_func3 = 3'b010;
         load_pd = 7'd2; load_rob_tag = 5'd2;
         if (load_valid && load_ready) accepts++;
         tick;
         if (load_done) begin
            pulses++;
            chk("stream_data", load_data, 32'hCAFEF00D);
         end
         if (int'(sq_count) > maxc) maxc = int'(sq_count);
      end
      store_wb = 1'b0; load_valid = 1'b0;
      for (int n = 0; n < 30; n++) begin
         if (load_ready && sq_count == 3'd0) break;
         tick;
         if (load_done) pulses++;
      end
      chk("stream_max_count", 32'(maxc), 32'd4);
      chk("stream_pulses", 32'(pulses), 32'(accepts));
      for (int i = 0; i < 8; i++) begin
         do_load(32'h40 + 32'(4 * i), 3'b010, 7'd3, 5'd3, 1'b0, '0, '0, 1'b0, rd, lat);
         chk("stream_landed", rd, 32'h5A000000 + 32'(i) * 32'h01010101);
      end

      // Flush kills a held load
      load_valid = 1'b1; load_addr = 32'h10; load_func3 = 3'b010; load_pd = 7'd9; load_rob_tag = 5'd9;
      tick;
      load_valid = 1'b0; flush = 1'b1;
      #1;
      chk("flush_ready_low", 32'(load_ready), 32'd0);
      tick;
      flush = 1'b0;
      #1;
      chk("flush_no_done", 32'(load_done), 32'd0);
      chk("flush_ready_back", 32'(load_ready), 32'd1);
      tick;
      chk("flush_no_done2", 32'(load_done), 32'd0);

      // Reset with three stores queued and a load held
      do_store(32'h88, 32'h0, 1'b0);
      do_store(32'h8C, 32'h0, 1'b0);
      do_store(32'h90, 32'h0, 1'b0);
      wait_drain;
      for (int i = 0; i < 5; i++) begin
         store_wb = 1'b1; store_addr = 32'h80 + 32'(4 * i); store_data = 32'h77000000 + 32'(i);
         store_sh = 1'b0;
         load_valid = 1'b1; load_addr = 32'h100; load_func3 = 3'b010;
         tick;
      end
      chk("pre_rst_count", 32'(sq_count), 32'd3);
      chk("pre_rst_hold", 32'(load_ready), 32'd0);
      store_wb = 1'b0; load_valid = 1'b0; reset = 1'b1;
      tick;
      reset = 1'b0;
      #1;
      chk("mid_rst_count", 32'(sq_count), 32'd0);
      chk("mid_rst_done", 32'(load_done), 32'd0);
      chk("mid_rst_data", load_data, 32'h0);
      chk("mid_rst_pd", 32'(load_pd_out), 32'd0);
      chk("mid_rst_rob", 32'(load_rob_out), 32'd0);
      chk("mid_rst_idle", 32'(load_ready), 32'd1);
      tick;
      do_load(32'h80, 3'b010, 7'd1, 5'd1, 1'b0, '0, '0, 1'b0, rd, lat);
      chk("rst_drained0", rd, 32'h77000000);
      do_load(32'h84, 3'b010, 7'd1, 5'd1, 1'b0, '0, '0, 1'b0, rd, lat);
      chk("rst_drained1", rd, 32'h77000001);
      do_load(32'h88, 3'b010, 7'd1, 5'd1, 1'b0, '0, '0, 1'b0, rd, lat);
      chk("rst_dropped2", rd, 32'h0);
      do_load(32'h8C, 3'b010, 7'd1, 5'd1, 1'b0, '0, '0, 1'b0, rd, lat);
      chk("rst_dropped3", rd, 32'h0);
      do_load(32'h90, 3'b010, 7'd1, 5'd1, 1'b0, '0, '0, 1'b0, rd, lat);
      chk("rst_dropped4", rd, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
